phase_meas_sequencer: RTL
=========================

Name: phase_meas_sequencer

Overview:
Sequences phase-difference measurements across NCH measurement inputs that share one signals_counter instance.
- Drives the MES input mux select and the counter's reset.
- Discards settling periods after each channel switch.
- Averages 2^LOG2_AVG signed phase samples per channel.
- Emits one result per channel, with start/busy/done handshake and a timeout for a missing REF.

Parameters:
NCH, 4, number of MES channels multiplexed into the counter
CH_W, 2, width of channel index (clog2 NCH, min 1)
LOG2_AVG, 3, log2 of samples averaged per channel
SETTLE, 2, REF periods discarded after each channel switch (0 allowed)
SAMPLE_DLY, 4, clock cycles from detected REF posedge to sampling diff_in
TIMEOUT, 1000000, max clock cycles between REF posedges before abort

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to begin a sweep
continuous  in  1  repeat sweeps while high
ch_mask  in  NCH  per-channel enable, sampled at start
ref_in  in  1  REF signal (asynchronous)
diff_in  in  32  counter DIFF output
sign_in  in  1  counter sign output
mes_sel  out  CH_W  MES mux select
meas_rst  out  1  reset to the shared counter
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
res_valid  out  1  one-cycle result strobe
res_ch  out  CH_W  channel of result
res_value  out  33  signed averaged phase, in clock counts
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset values: mes_sel=0, meas_rst=1, busy=0, done=0, res_valid=0, res_ch=0, res_value=0, timeout_err=0, state=IDLE.
- Reset asserted mid-operation returns the block to IDLE in the next cycle. Accumulator and all counters clear.
- REF input: 2-FF synchronizer followed by a posedge detector. ref_edge is a 1-cycle pulse.
- Sample value: s = sign_in ? -diff_in : +diff_in, 33-bit two's complement.
- Accumulator: 33+LOG2_AVG bits, signed.
- Average: res_value = acc >>> LOG2_AVG, an arithmetic shift that truncates toward minus infinity.
- IDLE:
  - meas_rst=0, busy=0.
  - On start, latch ch_mask, clear timeout_err, and go to NEXT with index=-1, so the search begins at channel 0.
  - If the latched mask is 0: done pulses the following cycle, no results are emitted, and the block returns to IDLE.
- NEXT:
  - Find the lowest enabled channel above index.
  - If none remains: when continuous=1 and mask≠0, wrap to the lowest enabled channel; otherwise pulse done and go to IDLE.
  - The search takes 1 cycle.
- SELECT: set mes_sel to the chosen channel and hold meas_rst=1 for 2 cycles, then go to SETTLE.
- SETTLE: count SETTLE ref_edges, then go to ACCUM. With SETTLE=0, go straight to ACCUM.
- ACCUM:
  - On each ref_edge, wait SAMPLE_DLY cycles, then add s to acc.
  - After 2^LOG2_AVG samples, go to OUTPUT.
  - A ref_edge arriving inside a pending delay window is ignored; it is not queued.
- OUTPUT:
  - res_valid=1 for 1 cycle with res_ch and res_value. Results hold until the next strobe.
  - Clear acc, then go to NEXT.
- Timeout:
  - A watchdog counts in SETTLE/ACCUM and restarts on every ref_edge and on entry to SELECT.
  - When it reaches TIMEOUT: set timeout_err (sticky until next start), emit no result for that channel, and go to NEXT.
- start while busy is ignored.
- continuous falling mid-sweep: the current sweep completes, then done pulses.
- busy=1 in all states except IDLE.

Decomposition:
- Shared package: state encoding (IDLE, NEXT, SELECT, SETTLE, ACCUM, OUTPUT) and widths DIFF_W=32, RES_W=33.
- One sub-module: ref_edge_sync (2-FF synchronizer plus posedge pulse), reusable by other LI-Sensor blocks.

Test Plan:
- NCH=4, mask=4'b1111, LOG2_AVG=3, diff_in=100, sign_in=0, REF period 50 cycles -> res_valid 4 times, res_ch 0..3, res_value=+100 each; done once; busy low afterwards.
- diff_in=7, sign_in=1 constant -> res_value=-7 (33'h1_FFFF_FFF9).
- Samples alternating +3/-4 (8 samples, sum -4) -> res_value=-1 (arithmetic shift).
- mask=4'b1010, continuous=1 for 2 sweeps, then dropped -> result order 1,3,1,3; done after the 4th result.
- REF stopped during ACCUM of ch2, TIMEOUT=200 -> no ch2 result, timeout_err=1 about 200 cycles after last edge, ch3 proceeds; next start clears timeout_err.
- reset asserted mid-ACCUM -> next cycle busy=0, meas_rst=1, mes_sel=0; mask=0 start -> done pulse with zero res_valid.

Source files
------------

// File: rtl/phase_meas_sequencer_pkg.sv
// Shared types and widths for the phase measurement sequencer.
package phase_meas_sequencer_pkg;

  localparam int DIFF_W = 32;
  localparam int RES_W  = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEXT,
    ST_SELECT,
    ST_SETTLE,
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  // Converts the counter's magnitude/sign pair into a 33-bit two's complement sample.
  function automatic logic signed [RES_W-1:0] signed_sample(input logic [DIFF_W-1:0] diff,
                                                            input logic              sign);
    logic signed [RES_W-1:0] mag;
    mag = $signed({1'b0, diff});
    return sign ? -mag : mag;
  endfunction

endpackage

// File: rtl/phase_meas_sequencer_ref_edge_sync.sv
// Two-flop synchronizer for an asynchronous reference signal plus a
// single-cycle rising-edge pulse on the synchronized copy.
module ref_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic sync_prev;

  // Bring the asynchronous input into the clock domain and keep its last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= async_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_pulse = sync2 & ~sync_prev;

endmodule

// File: rtl/phase_meas_sequencer.sv
// Sweeps the enabled MES channels through one shared signals_counter,
// discards settling periods, averages signed phase samples and reports
// one result per channel, with a REF watchdog that skips dead channels.
module phase_meas_sequencer
  import phase_meas_sequencer_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CH_W       = 2,
  parameter int LOG2_AVG   = 3,
  parameter int SETTLE     = 2,
  parameter int SAMPLE_DLY = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              ref_in,
  input  logic [DIFF_W-1:0] diff_in,
  input  logic              sign_in,
  output logic [CH_W-1:0]   mes_sel,
  output logic              meas_rst,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [RES_W-1:0]  res_value,
  output logic              timeout_err
);

  localparam int ACC_W  = RES_W + LOG2_AVG;
  localparam int NAVG   = 1 << LOG2_AVG;
  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DLY_W  = (SAMPLE_DLY > 0) ? $clog2(SAMPLE_DLY + 1) : 1;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SMP_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  state_t state;
  state_t state_next;

  logic                    ref_edge;
  logic [NCH-1:0]          mask_q;
  logic [CH_W-1:0]         cur_ch;
  logic                    have_cur;
  logic                    found_above;
  logic                    found_any;
  logic [CH_W-1:0]         ch_above;
  logic [CH_W-1:0]         ch_any;
  logic [CH_W-1:0]         nxt_ch;
  logic                    sel_cnt;
  logic [SCNT_W-1:0]       settle_cnt;
  logic                    settle_done;
  logic                    dly_active;
  logic [DLY_W-1:0]        dly_cnt;
  logic [SMP_W-1:0]        smp_cnt;
  logic                    sample_now;
  logic                    last_sample;
  logic [WD_W-1:0]         wd_cnt;
  logic                    timeout_hit;
  logic signed [ACC_W-1:0] acc;
  logic signed [RES_W-1:0] sample_val;
  logic signed [ACC_W-1:0] sample_ext;
  logic [RES_W-1:0]        avg;

  logic [CH_W-1:0]         mes_sel_nxt;
  logic                    meas_rst_nxt;
  logic                    done_nxt;
  logic                    res_valid_nxt;
  logic [CH_W-1:0]         res_ch_nxt;
  logic [RES_W-1:0]        res_value_nxt;

  ref_edge_sync u_ref_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (ref_in),
    .edge_pulse (ref_edge)
  );

  assign sample_val = signed_sample(diff_in, sign_in);
  assign sample_ext = ACC_W'(sample_val);
  assign avg        = RES_W'(acc >>> LOG2_AVG);
  assign nxt_ch     = found_above ? ch_above : ch_any;
  assign busy       = (state != ST_IDLE);

  assign settle_done = ref_edge && (settle_cnt == SCNT_W'(SETTLE - 1));
  assign last_sample = sample_now && (smp_cnt == SMP_W'(NAVG - 1));
  assign timeout_hit = ((state == ST_SETTLE) || (state == ST_ACCUM)) && !ref_edge &&
                       (wd_cnt == WD_W'(TIMEOUT - 1));

  // Decide whether this cycle is the end of a post-edge sampling delay.
  always_comb begin
    sample_now = 1'b0;
    if (state == ST_ACCUM) begin
      if (SAMPLE_DLY == 0) sample_now = ref_edge;
      else                 sample_now = dly_active && (dly_cnt == DLY_W'(1));
    end
  end

  // Find the lowest enabled channel above the current one, and the lowest overall for wrapping.
  always_comb begin
    found_above = 1'b0;
    found_any   = 1'b0;
    ch_above    = '0;
    ch_any      = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        found_any = 1'b1;
        ch_any    = CH_W'(i);
        if (!have_cur || (CH_W'(i) > cur_ch)) begin
          found_above = 1'b1;
          ch_above    = CH_W'(i);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic for the sweep sequence.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_NEXT;
      ST_NEXT: begin
        if (found_above || (continuous && found_any)) state_next = ST_SELECT;
        else                                          state_next = ST_IDLE;
      end
      ST_SELECT: if (sel_cnt) state_next = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
      ST_SETTLE: begin
        if (timeout_hit)      state_next = ST_NEXT;
        else if (settle_done) state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (timeout_hit)      state_next = ST_NEXT;
        else if (last_sample) state_next = ST_OUTPUT;
      end
      ST_OUTPUT: state_next = ST_NEXT;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    mes_sel_nxt   = mes_sel;
    res_ch_nxt    = res_ch;
    res_value_nxt = res_value;
    if ((state == ST_NEXT) && (state_next == ST_SELECT)) mes_sel_nxt = nxt_ch;
    meas_rst_nxt  = (state_next == ST_SELECT);
    done_nxt      = (state == ST_NEXT) && (state_next == ST_IDLE);
    res_valid_nxt = (state == ST_OUTPUT);
    if (state == ST_OUTPUT) begin
      res_ch_nxt    = cur_ch;
      res_value_nxt = avg;
    end
  end

  // Output registers; the counter is held in reset while the block itself is in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mes_sel   <= '0;
      meas_rst  <= 1'b1;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_value <= '0;
    end else begin
      mes_sel   <= mes_sel_nxt;
      meas_rst  <= meas_rst_nxt;
      done      <= done_nxt;
      res_valid <= res_valid_nxt;
      res_ch    <= res_ch_nxt;
      res_value <= res_value_nxt;
    end
  end

  // Channel bookkeeping, settle/sample counters, watchdog and accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q      <= '0;
      cur_ch      <= '0;
      have_cur    <= 1'b0;
      sel_cnt     <= 1'b0;
      settle_cnt  <= '0;
      dly_active  <= 1'b0;
      dly_cnt     <= '0;
      smp_cnt     <= '0;
      acc         <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        mask_q      <= ch_mask;
        have_cur    <= 1'b0;
        timeout_err <= 1'b0;
      end

      if ((state == ST_NEXT) && (state_next == ST_SELECT)) begin
        cur_ch   <= nxt_ch;
        have_cur <= 1'b1;
      end

      sel_cnt <= (state == ST_SELECT) ? ~sel_cnt : 1'b0;

      if (state == ST_SELECT) begin
        settle_cnt <= '0;
        smp_cnt    <= '0;
        acc        <= '0;
        wd_cnt     <= '0;
      end

      if ((state == ST_SETTLE) || (state == ST_ACCUM)) begin
        if (ref_edge) wd_cnt <= '0;
        else          wd_cnt <= wd_cnt + 1'b1;
      end

      if ((state == ST_SETTLE) && ref_edge) settle_cnt <= settle_cnt + 1'b1;

      if ((state == ST_ACCUM) && (SAMPLE_DLY != 0)) begin
        if (dly_active) begin
          dly_cnt <= dly_cnt - 1'b1;
          if (dly_cnt == DLY_W'(1)) dly_active <= 1'b0;
        end else if (ref_edge) begin
          dly_active <= 1'b1;
          dly_cnt    <= DLY_W'(SAMPLE_DLY);
        end
      end else begin
        dly_active <= 1'b0;
      end

      if (sample_now) begin
        acc     <= acc + sample_ext;
        smp_cnt <= smp_cnt + 1'b1;
      end

      if (timeout_hit) timeout_err <= 1'b1;

      if (state == ST_OUTPUT) begin
        acc     <= '0;
        smp_cnt <= '0;
      end
    end
  end

endmodule
